// File: rtl/softmax_engine_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | softmax_engine_arbiter_if: head requests, engine handshake and   |
// | arbiter status bundle.                    Revision: 1.0          |
// +-----------------------------------------------------------------+
interface softmax_engine_arbiter_if #(
  parameter int NUM_HEADS = 4
);
  localparam int HEAD_W = $clog2(NUM_HEADS);

  logic [NUM_HEADS-1:0] req;
  logic [NUM_HEADS-1:0] head_done;
  logic [NUM_HEADS-1:0] head_err;
  logic [HEAD_W-1:0]    sel_head;
  logic                 busy;
  logic                 eng_start;
  logic                 eng_done;
  logic                 eng_rst;
  logic [7:0]           err_count;

  modport master (
    input  req, eng_done,
    output head_done, head_err, sel_head, busy, eng_start, eng_rst, err_count
  );

  modport slave (
    output req, eng_done,
    input  head_done, head_err, sel_head, busy, eng_start, eng_rst, err_count
  );
endinterface
`default_nettype wire

// File: rtl/softmax_engine_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | softmax_engine_arbiter: round-robin sharing of one softmax       |
// | engine between heads, with hung-engine watchdog. Revision: 1.0   |
// +-----------------------------------------------------------------+
module softmax_engine_arbiter #(
  parameter int NUM_HEADS      = 4,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  wire logic                clk,
  input  wire logic                rst,
  softmax_engine_arbiter_if.master bus
);
  localparam int HEAD_W = $clog2(NUM_HEADS);
  // A disabled watchdog still needs a legal one-bit counter.
  localparam int TMR_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [HEAD_W:0]   NH       = (HEAD_W + 1)'(NUM_HEADS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_BUSY   = 3'd2,
    S_FINISH = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [HEAD_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HEAD_W-1:0]    sel_head_q, sel_head_d;
  logic                 busy_q, busy_d;
  logic                 eng_start_q, eng_start_d;
  logic                 eng_rst_q, eng_rst_d;
  logic [NUM_HEADS-1:0] head_done_q, head_done_d;
  logic [NUM_HEADS-1:0] head_err_q, head_err_d;
  logic [7:0]           err_count_q, err_count_d;
  logic [TMR_W-1:0]     timer_q, timer_d;

  logic                 found;
  logic [HEAD_W-1:0]    pick;
  logic [HEAD_W:0]      idx;
  logic [HEAD_W:0]      ptr_inc;
  logic [HEAD_W-1:0]    next_ptr;
  logic [NUM_HEADS-1:0] sel_onehot;
  logic                 timeout_hit;

  // First requesting head at or after rr_ptr, wrapping modulo NUM_HEADS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_HEADS; i++) begin
      idx = {1'b0, rr_ptr_q} + (HEAD_W + 1)'(i);
      if (idx >= NH) begin
        idx = idx - NH;
      end
      if (!found && bus.req[idx[HEAD_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[HEAD_W-1:0];
      end
    end
  end

  assign ptr_inc     = {1'b0, sel_head_q} + 1'b1;
  assign next_ptr    = (ptr_inc == NH) ? '0 : ptr_inc[HEAD_W-1:0];
  assign sel_onehot  = {{(NUM_HEADS-1){1'b0}}, 1'b1} << sel_head_q;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_head_d  = sel_head_q;
    busy_d      = busy_q;
    eng_start_d = 1'b0;
    eng_rst_d   = 1'b0;
    head_done_d = '0;
    head_err_d  = '0;
    err_count_d = err_count_q;
    timer_d     = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_head_d  = pick;
          busy_d      = 1'b1;
          eng_start_d = 1'b1;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        timer_d = timer_q + 1'b1;
        // A done arriving on the last allowed cycle still counts as success.
        if (bus.eng_done) begin
          head_done_d = sel_onehot;
          state_d     = S_FINISH;
        end else if (timeout_hit) begin
          head_done_d = sel_onehot;
          head_err_d  = sel_onehot;
          eng_rst_d   = 1'b1;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
          state_d     = S_ERROR;
        end
      end
      S_FINISH, S_ERROR: begin
        rr_ptr_d = next_ptr;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      sel_head_q  <= '0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_rst_q   <= 1'b0;
      head_done_q <= '0;
      head_err_q  <= '0;
      err_count_q <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_head_q  <= sel_head_d;
      busy_q      <= busy_d;
      eng_start_q <= eng_start_d;
      eng_rst_q   <= eng_rst_d;
      head_done_q <= head_done_d;
      head_err_q  <= head_err_d;
      err_count_q <= err_count_d;
      timer_q     <= timer_d;
    end
  end

  assign bus.head_done = head_done_q;
  assign bus.head_err  = head_err_q;
  assign bus.sel_head  = sel_head_q;
  assign bus.busy      = busy_q;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_rst   = eng_rst_q;
  assign bus.err_count = err_count_q;
endmodule
`default_nettype wire

// File: tb/tb_softmax_engine_arbiter.sv
`default_nettype none
// tb_softmax_engine_arbiter: randomized jobs checked against a simple
// round-robin / watchdog reference model of the arbitration rules.
module tb_softmax_engine_arbiter;
  localparam int NH  = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  softmax_engine_arbiter_if #(.NUM_HEADS(NH)) bus ();

  softmax_engine_arbiter #(.NUM_HEADS(NH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int total = 0;
  int bad   = 0;
  int m_ptr  = 0;
  int m_errs = 0;

  typedef struct {
    bit          ok;
    int          wait_c;
    int          grant;
    bit          start_one;
    bit          sel_stable;
    int          done_at;
    logic [NH-1:0] hd;
    logic [NH-1:0] he;
    logic        er;
    logic        bsy;
    logic [7:0]  ec;
    logic        post_busy;
    logic [NH-1:0] post_hd;
  } job_t;

  // Reference: first requesting head at or after ptr, modulo NH.
  function automatic int model_grant(input logic [NH-1:0] r, input int ptr);
    for (int i = 0; i < NH; i++) begin
      int h;
      h = (ptr + i) % NH;
      if (((r >> h) & 1) != 0) return h;
    end
    return -1;
  endfunction

  // Engine side of one job. k = BUSY cycle on which eng_done is driven,
  // 0 = never answer. Returns at the IDLE-cycle negedge after head_done.
  task automatic drive_job(input int k, output job_t j);
    logic [1:0] sel0;
    j.ok = 1'b1; j.wait_c = 0; j.grant = -1; j.start_one = 1'b0;
    j.sel_stable = 1'b1; j.done_at = 0; j.hd = '0; j.he = '0; j.er = 1'b0;
    j.bsy = 1'b0; j.ec = '0; j.post_busy = 1'b0; j.post_hd = '0;
    do begin
      @(negedge clk);
      j.wait_c++;
    end while (!bus.eng_start && j.wait_c < 8);
    if (!bus.eng_start) begin
      j.ok = 1'b0;
      return;
    end
    j.grant = int'(bus.sel_head);
    sel0 = bus.sel_head;
    @(negedge clk);
    j.start_one = !bus.eng_start;
    j.done_at = 1;
    if (k > 0) begin
      while (j.done_at < k) begin
        @(negedge clk);
        j.done_at++;
        if (bus.sel_head !== sel0) j.sel_stable = 1'b0;
      end
      bus.eng_done = 1'b1;
      @(negedge clk);
      bus.eng_done = 1'b0;
      j.done_at++;
    end else begin
      while (bus.head_done == '0 && j.done_at < 40) begin
        @(negedge clk);
        j.done_at++;
        if (bus.sel_head !== sel0) j.sel_stable = 1'b0;
      end
    end
    j.hd = bus.head_done; j.he = bus.head_err; j.er = bus.eng_rst;
    j.bsy = bus.busy; j.ec = bus.err_count;
    @(negedge clk);
    j.post_busy = bus.busy; j.post_hd = bus.head_done;
    if (bus.sel_head !== sel0) j.sel_stable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = '0; bus.eng_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.busy, bus.eng_start, bus.eng_rst, bus.head_done, bus.head_err,
         bus.sel_head, bus.err_count} !== '0) begin
      bad++; $display("FAIL reset_outputs got busy=%b start=%b erst=%b hd=%b he=%b sel=%0d ec=%0d want all 0",
                      bus.busy, bus.eng_start, bus.eng_rst, bus.head_done, bus.head_err, bus.sel_head, bus.err_count);
    end
    rst = 1'b0;
    @(negedge clk);
    m_ptr = 0; m_errs = 0;
  endtask

  task automatic test_single();
    job_t j;
    int k;
    k = int'($urandom_range(1, TMO));
    bus.req = 4'b0100;
    drive_job(k, j);
    bus.req = '0;
    total++; if (!j.ok || j.grant !== 2) begin bad++; $display("FAIL single_grant got=%0d want=2", j.grant); end
    total++; if (j.wait_c !== 1 || !j.start_one) begin bad++; $display("FAIL single_start got wait=%0d one=%0d want 1/1", j.wait_c, j.start_one); end
    total++; if (j.hd !== 4'b0100 || j.he !== '0 || j.er !== 1'b0) begin
      bad++; $display("FAIL single_done got hd=%b he=%b erst=%b want 0100/0000/0", j.hd, j.he, j.er); end
    total++; if (j.done_at !== k + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", j.done_at, k + 1); end
    total++; if (j.bsy !== 1'b1 || j.post_busy !== 1'b0 || j.post_hd !== '0) begin
      bad++; $display("FAIL single_busy got done_cyc=%b next=%b next_hd=%b want 1/0/0000", j.bsy, j.post_busy, j.post_hd); end
    m_ptr = 3;
  endtask

  task automatic test_priority();
    job_t j;
    logic [NH-1:0] pend;
    int cnt [NH];
    int g;
    for (int h = 0; h < NH; h++) cnt[h] = 0;
    pend = 4'b1011;
    bus.req = pend;
    while (pend != '0) begin
      g = model_grant(pend, m_ptr);
      drive_job(int'($urandom_range(1, TMO)), j);
      pend &= ~(NH'(1) << g);
      bus.req = pend;
      for (int h = 0; h < NH; h++) if (j.hd[h]) cnt[h]++;
      total++; if (!j.ok || j.grant !== g) begin bad++; $display("FAIL prio_grant got=%0d want=%0d", j.grant, g); end
      total++; if (j.wait_c !== 1) begin bad++; $display("FAIL prio_cadence got=%0d want=1", j.wait_c); end
      m_ptr = (g + 1) % NH;
    end
    total++;
    if (cnt[0] !== 1 || cnt[1] !== 1 || cnt[2] !== 0 || cnt[3] !== 1) begin
      bad++; $display("FAIL prio_done_count got=%0d,%0d,%0d,%0d want=1,1,0,1", cnt[0], cnt[1], cnt[2], cnt[3]);
    end
  endtask

  task automatic test_random();
    job_t j;
    logic [NH-1:0] pend;
    logic [NH-1:0] exp_hd;
    int k, g;
    pend = NH'($urandom_range(1, (1 << NH) - 1));
    bus.req = pend;
    for (int n = 0; n < 40; n++) begin
      k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TMO));
      g = model_grant(pend, m_ptr);
      exp_hd = NH'(1) << g;
      if (k == 0 && m_errs < 255) m_errs++;
      drive_job(k, j);
      pend &= ~exp_hd;
      pend |= NH'($urandom_range(0, (1 << NH) - 1)) & NH'($urandom_range(0, (1 << NH) - 1));
      if (pend == '0) pend = NH'($urandom_range(1, (1 << NH) - 1));
      bus.req = pend;
      total++; if (!j.ok || j.grant !== g) begin bad++; $display("FAIL rand_grant job=%0d got=%0d want=%0d", n, j.grant, g); end
      total++; if (j.hd !== exp_hd) begin bad++; $display("FAIL rand_done job=%0d got=%b want=%b", n, j.hd, exp_hd); end
      total++; if (j.he !== ((k == 0) ? exp_hd : '0) || j.er !== (k == 0)) begin
        bad++; $display("FAIL rand_err job=%0d got he=%b erst=%b timeout=%0d", n, j.he, j.er, k == 0); end
      total++; if (j.done_at !== ((k == 0) ? TMO + 1 : k + 1)) begin
        bad++; $display("FAIL rand_latency job=%0d got=%0d want=%0d", n, j.done_at, (k == 0) ? TMO + 1 : k + 1); end
      total++; if (j.ec !== 8'(m_errs)) begin bad++; $display("FAIL rand_errcnt job=%0d got=%0d want=%0d", n, j.ec, m_errs); end
      total++; if (j.wait_c !== 1 || !j.start_one || !j.sel_stable || j.post_busy !== 1'b0) begin
        bad++; $display("FAIL rand_proto job=%0d got wait=%0d one=%0d stable=%0d post_busy=%b", n, j.wait_c, j.start_one, j.sel_stable, j.post_busy); end
      m_ptr = (g + 1) % NH;
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    job_t j;
    int g;
    bus.req = '1;
    for (int n = 0; n < 8; n++) begin
      g = model_grant('1, m_ptr);
      drive_job(int'($urandom_range(1, TMO)), j);
      total++; if (!j.ok || j.grant !== g || !j.sel_stable) begin
        bad++; $display("FAIL fair_grant job=%0d got=%0d stable=%0d want=%0d", n, j.grant, j.sel_stable, g); end
      m_ptr = (g + 1) % NH;
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    job_t j;
    bus.req = 4'b0001;
    drive_job(0, j);
    if (m_errs < 255) m_errs++;
    total++; if (!j.ok || j.hd !== 4'b0001 || j.he !== 4'b0001 || j.er !== 1'b1) begin
      bad++; $display("FAIL tmo_pulses got hd=%b he=%b erst=%b want 0001/0001/1", j.hd, j.he, j.er); end
    total++; if (j.done_at !== TMO + 1) begin bad++; $display("FAIL tmo_latency got=%0d want=%0d", j.done_at, TMO + 1); end
    total++; if (j.ec !== 8'(m_errs)) begin bad++; $display("FAIL tmo_count got=%0d want=%0d", j.ec, m_errs); end
    for (int n = 0; n < 260; n++) begin
      drive_job(0, j);
      if (m_errs < 255) m_errs++;
      total++; if (j.ec !== 8'(m_errs)) begin bad++; $display("FAIL tmo_sat n=%0d got=%0d want=%0d", n, j.ec, m_errs); end
    end
    total++; if (bus.err_count !== 8'd255) begin bad++; $display("FAIL tmo_sat_final got=%0d want=255", bus.err_count); end
    m_ptr = 1;
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_done_at_limit();
    job_t j;
    int g;
    bus.req = 4'b0010;
    g = model_grant(4'b0010, m_ptr);
    drive_job(TMO, j);
    bus.req = '0;
    total++; if (!j.ok || j.grant !== g || j.hd !== 4'b0010) begin
      bad++; $display("FAIL limit_done got grant=%0d hd=%b want=%0d/0010", j.grant, j.hd, g); end
    total++; if (j.he !== '0 || j.er !== 1'b0 || j.ec !== 8'(m_errs)) begin
      bad++; $display("FAIL limit_noerr got he=%b erst=%b ec=%0d want 0000/0/%0d", j.he, j.er, j.ec, m_errs); end
    m_ptr = (g + 1) % NH;
    @(negedge clk);
  endtask

  task automatic test_idle_done();
    job_t j;
    int g;
    bit moved;
    moved = 1'b0;
    bus.eng_done = 1'b1;
    @(negedge clk);
    bus.eng_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.busy || bus.eng_start || bus.eng_rst || bus.head_done != '0 || bus.err_count != 8'(m_errs)) moved = 1'b1;
      @(negedge clk);
    end
    total++; if (moved) begin bad++; $display("FAIL idle_done got outputs changed want none"); end
    bus.req = 4'b0101;
    g = model_grant(4'b0101, m_ptr);
    drive_job(3, j);
    bus.req = '0;
    total++; if (!j.ok || j.grant !== g || j.done_at !== 4) begin
      bad++; $display("FAIL idle_followup got grant=%0d lat=%0d want=%0d/4", j.grant, j.done_at, g); end
    m_ptr = (g + 1) % NH;
  endtask

  task automatic test_reset_mid();
    job_t j;
    int c;
    bus.req = 4'b1000;
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.eng_start && c < 8);
    total++; if (!bus.eng_start) begin bad++; $display("FAIL rmid_start got=0 want=1"); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.eng_start, bus.eng_rst, bus.head_done, bus.head_err,
         bus.sel_head, bus.err_count} !== '0) begin
      bad++; $display("FAIL rmid_async got busy=%b sel=%0d ec=%0d want all 0", bus.busy, bus.sel_head, bus.err_count);
    end
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_errs = 0;
    total++; if (bus.head_done !== '0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rmid_nodone got hd=%b busy=%b want 0000/0", bus.head_done, bus.busy); end
    bus.req = '1;
    drive_job(2, j);
    bus.req = '0;
    total++; if (!j.ok || j.grant !== model_grant('1, m_ptr) || j.hd !== 4'b0001 || j.ec !== 8'd0) begin
      bad++; $display("FAIL rmid_regrant got grant=%0d hd=%b ec=%0d want 0/0001/0", j.grant, j.hd, j.ec); end
  endtask

  initial begin
    bus.req = '0;
    bus.eng_done = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_random();
    test_fairness();
    test_timeout();
    test_done_at_limit();
    test_idle_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
